fp_mul_norm_round: RTL and testbench
====================================

Name: fp_mul_norm_round

Overview:
Normalise-and-round stage placed directly after the 24x24 mantissa multiplier in the FP multiplier datapath. It takes the raw 48-bit mantissa product, the pre-biased exponent sum and the result sign, and produces the packed IEEE-754 single-precision result plus exception flags. It is a 2-stage pipeline with a valid/ready handshake on both sides, so the FP ALU top level can stall it.

Parameters:
- EXP_W, 10, width of the signed exponent-sum input (two's complement).
- FLAG_W, 3, width of the flags output as {overflow, underflow, inexact}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a product.
- in_ready  out  1  stage can accept a product this cycle.
- product  in  48  unsigned mantissa product (hidden bits included).
- exp_sum  in  EXP_W  signed value ea+eb-127.
- sign  in  1  result sign, sa^sb.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- flags  out  FLAG_W  {overflow, underflow, inexact}, aligned with result.

Behaviour:
- Reset: on rst=1 at a clock edge, s1_valid=0, s2_valid=0, out_valid=0, result=32'h0, flags=3'b000, and in_ready=1 from the next cycle. In-flight data is dropped, including mid-stall.
- A transfer happens when valid and ready are both high at a clock edge.
- in_ready is combinational: !s1_valid || s1_adv.
- s1_adv = !s2_valid || out_ready.
- Latency is 2 cycles from input accept to out_valid, with no stall. Throughput is 1 result per cycle.
- Stage 1 (normalise), registered:
  - If product[47]=1: m=product[46:24], g=product[23], s=|product[22:0], e=exp_sum+1.
  - Else: m=product[45:23], g=product[22], s=|product[21:0], e=exp_sum.
  - Also register zero = (product==0).
- Stage 2 (round and pack), registered into result/flags:
  - Round-to-nearest-even: up = g && (s || m[0]).
  - {c, mr} = m + up. If c=1: mr=0 and e=e+1.
  - zero: result={sign, 31'h0}, flags=000.
  - e>=255 (signed): result={sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
  - e<=0 (signed): flush to {sign, 31'h0}, underflow=1, inexact=1. No denormal output.
  - Otherwise: result={sign, e[7:0], mr}, inexact = g|s.
- result and flags hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in the same cycle with both stages full: no bubble, no loss.
- The product is never treated as having both bit 47 and bit 46 clear. That case is a valid zero or an upstream error, and it is normalised per the rule above.

Optional Feature:
- Macro FPMUL_RNE_EN.
- Defined: round-to-nearest-even as specified above.
- Undefined: truncation (round toward zero), i.e. up=0 always. The carry path is removed, inexact is still reported as g|s, and overflow/underflow rules are unchanged.

Test Plan:
- product=48'h900000000000, exp_sum=127, sign=0 -> result=32'h40100000 (2.25), flags=000, out_valid exactly 2 cycles after accept.
- product=48'h400000000000, exp_sum=127, sign=0 -> result=32'h3F800000 (1.0), flags=000.
- product=48'h7FFFFFC00001, exp_sum=127:
  - FPMUL_RNE_EN defined -> result=32'h40000000, flags=001 (rounding carry bumps exponent).
  - FPMUL_RNE_EN undefined -> result=32'h3FFFFFFF, flags=001.
- Exponent limits:
  - product=48'h800000000000, exp_sum=254, sign=1 -> result=32'hFF800000, flags=101.
  - product=48'h400000000000, exp_sum=0 -> result=32'h00000000, flags=011.
  - product=0, exp_sum=100, sign=1 -> result=32'h80000000, flags=000.
- Backpressure: drive 3 back-to-back valid inputs with out_ready=0 -> in_ready=0 after 2 accepts and the first result holds stable. Raise out_ready -> results emerge in order, 1 per cycle, no drops or duplicates.
- Assert rst for one cycle while both stages are full -> out_valid=0, result=0, flags=0 next cycle, and the pipeline accepts new input immediately after.

Source files
------------

// File: rtl/fp_mul_norm_round.sv
// rtl/fp_mul_norm_round.sv - normalise/round stage after the 24x24 mantissa multiplier, 2-stage valid/ready pipe.
// FPMUL_RNE_EN selects round-to-nearest-even; without it the stage truncates toward zero.
module fp_mul_norm_round #(
  parameter int EXP_W  = 10,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [47:0]       product,
  input  logic [EXP_W-1:0]  exp_sum,
  input  logic              sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic [FLAG_W-1:0] flags
);

  // Two guard bits: normalise can add 1 and the rounding carry another 1.
  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_MAX = E_W'(255);
  localparam logic signed [E_W-1:0] E_MIN = E_W'(0);

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_adv;
  logic [22:0]           s1_m;
  logic                  s1_g;
  logic                  s1_s;
  logic                  s1_zero;
  logic                  s1_sign;
  logic signed [E_W-1:0] s1_e;

  logic [22:0]           n_m;
  logic                  n_g;
  logic                  n_s;
  logic signed [E_W-1:0] n_e;

  logic [22:0]           mr;
  logic signed [E_W-1:0] e_r;
  logic [31:0]           nx_result;
  logic [FLAG_W-1:0]     nx_flags;

  logic [31:0]           result_q;
  logic [FLAG_W-1:0]     flags_q;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;
  assign result    = result_q;
  assign flags     = flags_q;

  // Stage 1: pick the 23 fraction bits below the leading one.
  always_comb begin
    n_m = product[45:23];
    n_g = product[22];
    n_s = |product[21:0];
    n_e = {{2{exp_sum[EXP_W-1]}}, exp_sum};
    if (product[47]) begin
      n_m = product[46:24];
      n_g = product[23];
      n_s = |product[22:0];
      n_e = {{2{exp_sum[EXP_W-1]}}, exp_sum} + E_W'(1);
    end
  end

`ifdef FPMUL_RNE_EN
  logic up;
  logic carry;
  assign up          = s1_g && (s1_s || s1_m[0]);
  assign {carry, mr} = {1'b0, s1_m} + {23'b0, up};
  assign e_r         = s1_e + {{(E_W-1){1'b0}}, carry};
`else
  assign mr  = s1_m;
  assign e_r = s1_e;
`endif

  // Stage 2: exception checks on the rounded exponent, then pack.
  always_comb begin
    nx_result = {s1_sign, e_r[7:0], mr};
    nx_flags  = FLAG_W'({2'b00, s1_g | s1_s});
    if (s1_zero) begin
      nx_result = {s1_sign, 31'h0};
      nx_flags  = FLAG_W'(3'b000);
    end else if (e_r >= E_MAX) begin
      nx_result = {s1_sign, 8'hFF, 23'h0};
      nx_flags  = FLAG_W'(3'b101);
    end else if (e_r <= E_MIN) begin
      nx_result = {s1_sign, 31'h0};
      nx_flags  = FLAG_W'(3'b011);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result_q <= 32'h0;
      flags_q  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result_q <= nx_result;
          flags_q  <= nx_flags;
        end
      end
    end
  end

  // Datapath registers need no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_m    <= n_m;
      s1_g    <= n_g;
      s1_s    <= n_s;
      s1_e    <= n_e;
      s1_zero <= (product == 48'h0);
      s1_sign <= sign;
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb/tb_fp_mul_norm_round.sv - self-checking bench for fp_mul_norm_round against an arithmetic reference model.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] product;
  logic [9:0]  exp_sum;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [34:0] exp_q[$];
  logic        ovr_en = 1'b0;
  logic [34:0] ovr;

  fp_mul_norm_round #(.EXP_W(10), .FLAG_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .exp_sum(exp_sum), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: keep 24 significant bits, round by comparing the discarded part with one half.
  function automatic logic [34:0] model(input logic [47:0] p, input logic signed [9:0] es, input logic sg);
    longint keep, rem, half;
    int e;
    logic inexact;
    if (p == 48'h0) return {3'b000, sg, 31'h0};
    if (p[47]) begin
      keep = longint'(p >> 24);
      rem  = longint'(p) & ((64'd1 << 24) - 1);
      half = 64'd1 << 23;
      e    = int'(es) + 1;
    end else begin
      keep = longint'(p >> 23);
      rem  = longint'(p) & ((64'd1 << 23) - 1);
      half = 64'd1 << 22;
      e    = int'(es);
    end
    inexact = (rem != 0);
`ifdef FPMUL_RNE_EN
    if (rem > half || (rem == half && keep % 2 == 1)) keep = keep + 1;
    if (keep >= (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
`endif
    if (e >= 255) return {3'b101, sg, 8'hFF, 23'h0};
    if (e <= 0) return {3'b011, sg, 31'h0};
    return {2'b00, inexact, sg, e[7:0], keep[22:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, score the output transfer and queue the input transfer.
  task automatic step(input logic iv, input logic [47:0] p, input logic [9:0] es,
                      input logic sg, input logic ordy);
    logic [34:0] e;
    @(negedge clk);
    in_valid  = iv;
    product   = p;
    exp_sum   = es;
    sign      = sg;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed=%0h expected=none", result);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e[31:0]));
        check("flags", 64'(flags), 64'(e[34:32]));
      end
      n_out++;
    end
    if (in_valid && in_ready && !rst)
      exp_q.push_back(ovr_en ? ovr : model(p, es, sg));
  endtask

  task automatic directed(input logic [47:0] p, input logic [9:0] es, input logic sg,
                          input logic [31:0] r, input logic [2:0] f);
    ovr    = {f, r};
    ovr_en = 1'b1;
    step(1'b1, p, es, sg, 1'b1);
    ovr_en = 1'b0;
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    logic [47:0] p;
    int v;
    int base;

    rst = 1'b1;
    in_valid = 1'b0; product = '0; exp_sum = '0; sign = 1'b0; out_ready = 1'b0;
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_flags", 64'(flags), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // 2.25 with exact latency check
    ovr = {3'b000, 32'h40100000};
    ovr_en = 1'b1;
    step(1'b1, 48'h900000000000, 10'd127, 1'b0, 1'b1);
    ovr_en = 1'b0;
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("latency_cycle1", 64'(out_valid), 64'(0));
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("latency_cycle2", 64'(out_valid), 64'(1));

    directed(48'h400000000000, 10'd127, 1'b0, 32'h3F800000, 3'b000);
`ifdef FPMUL_RNE_EN
    directed(48'h7FFFFFC00001, 10'd127, 1'b0, 32'h40000000, 3'b001);
`else
    directed(48'h7FFFFFC00001, 10'd127, 1'b0, 32'h3FFFFFFF, 3'b001);
`endif
    directed(48'h800000000000, 10'd254, 1'b1, 32'hFF800000, 3'b101);
    directed(48'h400000000000, 10'd0, 1'b0, 32'h00000000, 3'b011);
    directed(48'h000000000000, 10'd100, 1'b1, 32'h80000000, 3'b000);

    // Backpressure: third input must stall, head result must hold.
    step(1'b1, 48'hA00000000000, 10'd130, 1'b0, 1'b0);
    step(1'b1, 48'h500000000000, 10'd120, 1'b1, 1'b0);
    step(1'b1, 48'hC00000400000, 10'd127, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    held = result;
    step(1'b1, 48'hC00000400000, 10'd127, 1'b0, 1'b0);
    check("bp_hold", 64'(result), 64'(held));
    base = n_out;
    step(1'b1, 48'hC00000400000, 10'd127, 1'b0, 1'b1);
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("bp_stream_valid", 64'(out_valid), 64'(1));
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("bp_stream_valid2", 64'(out_valid), 64'(1));
    check("bp_count", 64'(n_out - base), 64'(3));
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("bp_empty", 64'(out_valid), 64'(0));

    // Reset with both stages full.
    step(1'b1, 48'h900000000000, 10'd127, 1'b0, 1'b0);
    step(1'b1, 48'h600000000000, 10'd140, 1'b1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_flags", 64'(flags), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    step(1'b1, 48'h480000000000, 10'd127, 1'b1, 1'b1);
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("midrst_drained", 64'(exp_q.size()), 64'(0));

    // Randomised traffic with random stalls.
    for (int i = 0; i < 500; i++) begin
      p = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) p[47] = 1'b1;
      else p[47:46] = 2'b01;
      if ($urandom_range(0, 3) == 0) p[21:0] = 22'h0;
      if ($urandom_range(0, 19) == 0) p = 48'h0;
      v = int'($urandom_range(0, 320)) - 40;
      step($urandom_range(0, 3) != 0, p, v[9:0], 1'($urandom), $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      step(1'b0, 48'h0, 10'd0, 1'b0, 1'b1);
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
